// File: rtl/mem_tid_allocator_pkg.sv
// Shared types for the memory transaction-ID allocator: ID typedef and drain FSM states.
package mem_tid_allocator_pkg;

  // Matches the core configuration field MemTidWidth.
  localparam int unsigned MemTidWidth = 2;

  typedef logic [MemTidWidth-1:0] mem_tid_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } tid_drain_state_e;

endpackage

// File: rtl/mem_tid_allocator_if.sv
// Request/release/drain bundle between the request arbiter (master) and the TID allocator (slave).
interface mem_tid_allocator_if
  import mem_tid_allocator_pkg::*;
#(
  parameter int unsigned TidWidth = MemTidWidth
);
  localparam int unsigned NumTids = 2**TidWidth;

  logic                alloc_req_i;
  logic                alloc_gnt_o;
  logic [TidWidth-1:0] alloc_tid_o;
  logic                rel_valid_i;
  logic [TidWidth-1:0] rel_tid_i;
  logic                drain_req_i;
  logic                drain_done_o;
  logic [NumTids-1:0]  busy_o;
  logic [TidWidth:0]   outstanding_o;
  logic                err_rel_o;
  logic                timeout_o;

  modport master (
    output alloc_req_i, rel_valid_i, rel_tid_i, drain_req_i,
    input  alloc_gnt_o, alloc_tid_o, drain_done_o, busy_o, outstanding_o, err_rel_o, timeout_o
  );

  modport slave (
    input  alloc_req_i, rel_valid_i, rel_tid_i, drain_req_i,
    output alloc_gnt_o, alloc_tid_o, drain_done_o, busy_o, outstanding_o, err_rel_o, timeout_o
  );

endinterface

// File: rtl/mem_tid_allocator_tid_rr_picker.sv
// Combinational round-robin finder: first non-busy ID at or after ptr_i, wrapping at NumTids-1.
module tid_rr_picker #(
  parameter  int unsigned TidWidth = 2,
  localparam int unsigned NumTids  = 2**TidWidth
) (
  input  logic [NumTids-1:0]  busy_i,
  input  logic [TidWidth-1:0] ptr_i,
  output logic [TidWidth-1:0] free_tid_o,
  output logic                found_o
);

  logic [TidWidth-1:0] idx;
  logic                found;

  // Index arithmetic wraps naturally in TidWidth bits; reports 0 when nothing is free.
  always_comb begin
    free_tid_o = '0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < NumTids; i++) begin
      idx = ptr_i + TidWidth'(i);
      if (!found && !busy_i[idx]) begin
        free_tid_o = idx;
        found      = 1'b1;
      end
    end
    found_o = found;
  end

endmodule

// File: rtl/mem_tid_allocator.sv
// Transaction-ID allocator with round-robin grant, release tracking and fence/flush drain.
// Define MEM_TID_ALLOC_TIMEOUT_EN to build per-ID age counters and the sticky timeout_o flag.
module mem_tid_allocator
  import mem_tid_allocator_pkg::*;
#(
  parameter int unsigned TidWidth = MemTidWidth
`ifdef MEM_TID_ALLOC_TIMEOUT_EN
  , parameter int unsigned TimeoutCycles = 1024
`endif
) (
  input logic               clk_i,
  input logic               rst_ni,
  mem_tid_allocator_if.slave bus
);

  localparam int unsigned NumTids = 2**TidWidth;
  localparam int unsigned CntW    = TidWidth + 1;

  tid_drain_state_e    state_q, state_d;
  logic [NumTids-1:0]  busy_q, busy_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [TidWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic                err_rel_q, err_rel_d;

  logic [TidWidth-1:0] free_tid;
  logic                any_free;
  logic                gnt;
  logic                rel_ok;

  tid_rr_picker #(.TidWidth(TidWidth)) u_picker (
    .busy_i     (busy_q),
    .ptr_i      (rr_ptr_q),
    .free_tid_o (free_tid),
    .found_o    (any_free)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping drain_req_i aborts a drain even while IDs are still outstanding.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.drain_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!bus.drain_req_i)     state_d = IDLE;
        else if (count_q == '0)   state_d = DONE;
      end
      DONE:    if (!bus.drain_req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt              = bus.alloc_req_i && (state_q == IDLE) && any_free;
    bus.alloc_gnt_o  = gnt;
    bus.alloc_tid_o  = free_tid;
    bus.drain_done_o = (state_q == DONE);
  end

  // A release only frees its bit next cycle, so the picker never sees a same-cycle bypass.
  always_comb begin
    rel_ok    = bus.rel_valid_i && busy_q[bus.rel_tid_i];
    err_rel_d = bus.rel_valid_i && !busy_q[bus.rel_tid_i];
    busy_d    = busy_q;
    rr_ptr_d  = rr_ptr_q;
    count_d   = count_q;
    if (gnt) begin
      busy_d[free_tid] = 1'b1;
      rr_ptr_d         = free_tid + TidWidth'(1);
    end
    if (rel_ok) begin
      busy_d[bus.rel_tid_i] = 1'b0;
    end
    if (gnt && !rel_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!gnt && rel_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= '0;
      count_q   <= '0;
      rr_ptr_q  <= '0;
      err_rel_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      count_q   <= count_d;
      rr_ptr_q  <= rr_ptr_d;
      err_rel_q <= err_rel_d;
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.outstanding_o = count_q;
  assign bus.err_rel_o     = err_rel_q;

`ifdef MEM_TID_ALLOC_TIMEOUT_EN
  localparam int unsigned AgeWidth = $clog2(TimeoutCycles + 1);

  logic [NumTids-1:0][AgeWidth-1:0] age_q, age_d;
  logic                             timeout_q, timeout_d;

  // Ages saturate at TimeoutCycles; the flag is sticky until reset.
  always_comb begin
    age_d     = age_q;
    timeout_d = timeout_q;
    for (int i = 0; i < NumTids; i++) begin
      if (gnt && (free_tid == TidWidth'(i))) begin
        age_d[i] = '0;
      end else if (busy_q[i] && (age_q[i] != AgeWidth'(TimeoutCycles))) begin
        age_d[i] = age_q[i] + AgeWidth'(1);
      end
      if (age_d[i] == AgeWidth'(TimeoutCycles)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      age_q     <= age_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign bus.timeout_o = 1'b0;
`endif

  a_count_popcount: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(count_q) == $countones(busy_q));

endmodule

// File: tb/tb_mem_tid_allocator.sv
// Scoreboard bench for mem_tid_allocator: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_mem_tid_allocator;
  import mem_tid_allocator_pkg::*;

  typedef struct {
    int       cyc;
    mem_tid_t tid;
  } gnt_exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] busy;
    logic [2:0] cnt;
    logic       done;
  } stat_exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  gnt_exp_t  gnt_q[$];
  stat_exp_t stat_q[$];
  int        err_q[$];

  mem_tid_allocator_if #(.TidWidth(2)) dut_if ();

  mem_tid_allocator dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic rel_v, input mem_tid_t rel_t, input logic drain);
    dut_if.alloc_req_i = req;
    dut_if.rel_valid_i = rel_v;
    dut_if.rel_tid_i   = rel_t;
    dut_if.drain_req_i = drain;
  endtask

  task automatic expectGrant(input mem_tid_t tid);
    gnt_exp_t e;
    e.cyc = cyc;
    e.tid = tid;
    gnt_q.push_back(e);
  endtask

  task automatic expectErr();
    err_q.push_back(cyc);
  endtask

  task automatic checkOutput(input logic [3:0] busy, input logic [2:0] cnt, input logic done);
    stat_exp_t e;
    e.cyc  = cyc;
    e.busy = busy;
    e.cnt  = cnt;
    e.done = done;
    stat_q.push_back(e);
  endtask

  // Monitor: every expectation is tagged with the cycle it must appear in.
  always @(negedge clk) begin
    if (dut_if.alloc_gnt_o) begin
      n_cmp++;
      if (gnt_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL grant: got tid=%0d at cycle %0d, required no grant", dut_if.alloc_tid_o, cyc);
      end else begin
        gnt_exp_t e;
        e = gnt_q.pop_front();
        if (e.cyc != cyc || e.tid != dut_if.alloc_tid_o) begin
          n_fail++;
          $display("[TB] FAIL grant: got tid=%0d at cycle %0d, required tid=%0d at cycle %0d",
                   dut_if.alloc_tid_o, cyc, e.tid, e.cyc);
        end
      end
    end else if (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc) begin
      gnt_exp_t e;
      e = gnt_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL grant: got none at cycle %0d, required tid=%0d", cyc, e.tid);
    end

    if (dut_if.err_rel_o) begin
      n_cmp++;
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        void'(err_q.pop_front());
      end else begin
        n_fail++;
        $display("[TB] FAIL err_rel: got 1 at cycle %0d, required 0", cyc);
      end
    end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
      void'(err_q.pop_front());
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL err_rel: got 0 at cycle %0d, required 1", cyc);
    end

    while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
      stat_exp_t e;
      e = stat_q.pop_front();
      n_cmp += 3;
      if (dut_if.busy_o !== e.busy) begin
        n_fail++;
        $display("[TB] FAIL busy: got %b at cycle %0d, required %b", dut_if.busy_o, cyc, e.busy);
      end
      if (dut_if.outstanding_o !== e.cnt) begin
        n_fail++;
        $display("[TB] FAIL outstanding: got %0d at cycle %0d, required %0d", dut_if.outstanding_o, cyc, e.cnt);
      end
      if (dut_if.drain_done_o !== e.done) begin
        n_fail++;
        $display("[TB] FAIL drain_done: got %b at cycle %0d, required %b", dut_if.drain_done_o, cyc, e.done);
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    checkOutput(4'b0000, 3'd0, 1'b0);
    tick();

    // Fill all four IDs in order, then a full cycle with no grant.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
      expectGrant(mem_tid_t'(k));
      tick();
    end
    checkOutput(4'b1111, 3'd4, 1'b0);
    tick();

    // Release while full: the freed ID is grantable only the following cycle.
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    expectGrant(2'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput(4'b1111, 3'd4, 1'b0);
    tick();

    // Mid-operation reset, then busy=0011/ptr=2 with simultaneous grant and release.
    rst_n = 1'b0;
    checkOutput(4'b0000, 3'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    expectGrant(2'd0);
    tick();
    expectGrant(2'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0);
    expectGrant(2'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput(4'b0110, 3'd2, 1'b0);
    tick();

    // Release of a non-busy ID pulses err_rel_o once and changes nothing.
    rst_n = 1'b0;
    checkOutput(4'b0000, 3'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    expectGrant(2'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b0);
    checkOutput(4'b0001, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    expectErr();
    checkOutput(4'b0001, 3'd1, 1'b0);
    tick();
    checkOutput(4'b0001, 3'd1, 1'b0);

    // Build busy=0101 for the drain scenario.
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    expectGrant(2'd1);
    tick();
    expectGrant(2'd2);
    tick();
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkOutput(4'b0101, 3'd2, 1'b0);
    tick();

    // Drain: requests held but not granted; done the cycle after outstanding reaches 0.
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
    checkOutput(4'b0101, 3'd2, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b1);
    checkOutput(4'b0100, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
    checkOutput(4'b0000, 3'd0, 1'b0);
    tick();
    checkOutput(4'b0000, 3'd0, 1'b1);
    tick();
    checkOutput(4'b0000, 3'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    expectGrant(2'd3);
    checkOutput(4'b0000, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkOutput(4'b1000, 3'd1, 1'b0);
    tick();

    // Drain aborted while an ID is still outstanding; grants resume with wrap to 0.
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    checkOutput(4'b1000, 3'd1, 1'b0);
    tick();
    expectGrant(2'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput(4'b1001, 3'd2, 1'b0);
    repeat (3) tick();

    foreach (gnt_q[i]) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL grant: never seen, required tid=%0d at cycle %0d", gnt_q[i].tid, gnt_q[i].cyc);
    end
    foreach (err_q[i]) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL err_rel: never seen, required pulse at cycle %0d", err_q[i]);
    end
    foreach (stat_q[i]) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL status: never sampled, required at cycle %0d", stat_q[i].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
